// File: rtl/chnlnk_pkg.sv
// Shared definitions for the channel-link receive deframer: state encodings,
// frame geometry, trailer markers, error bit positions and the CRC step function.
package chnlnk_pkg;

  localparam int CHN_DW    = 16;
  localparam int CHN_NDATA = 96;
  localparam int CHN_NTAIL = 3;

  localparam logic [15:0] CHN_CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'h1021;

  localparam logic [3:0] TRL_SMP_MARK = 4'hD;
  localparam logic [3:0] TRL_MAX_MARK = 4'hE;

  localparam int ERR_GAP = 0;
  localparam int ERR_TRL = 1;
  localparam int ERR_CRC = 2;
  localparam int ERR_SMP = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_TAIL = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4,
    ST_ERRW = 3'd5
  } rcv_state_t;

  // One full 16-bit word through CRC-16-CCITT, MSB first.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/chnlnk_crc16.sv
// Parallel CRC-16-CCITT accumulator; clr reloads the seed and wins over en.
module chnlnk_crc16
  import chnlnk_pkg::*;
#(
  parameter logic [15:0] INIT = CHN_CRC_INIT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset loads the seed rather than zero so the first frame after reset checks correctly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      r_crc <= INIT;
    else if (clr) r_crc <= INIT;
    else if (en)  r_crc <= crc16_next(r_crc, d);
  end

  assign crc = r_crc;

endmodule

// File: rtl/chnlnk_frame_rcv_fsm.sv
// Receive-side deframer: checks per-sample framing, trailer and CRC, writes data
// words to the event buffer at {smp,seq} and reports event done/error status.
module chnlnk_frame_rcv_fsm
  import chnlnk_pkg::*;
#(
  parameter int          DW       = CHN_DW,
  parameter int          NDATA    = CHN_NDATA,
  parameter logic [15:0] CRC_INIT = CHN_CRC_INIT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [6:0]    SAMP_MAX,
  input  logic          VALID,
  input  logic [DW-1:0] DIN,
  input  logic          LAST_WRD,
  output logic          WR_EN,
  output logic [13:0]   WR_ADDR,
  output logic [DW-1:0] WR_DATA,
  output logic          EVT_DONE,
  output logic          EVT_ERR,
  output logic [3:0]    ERR_CODE,
  output logic [2:0]    RCV_STATE
);

  localparam logic [6:0] SEQ_DLAST = 7'(NDATA - 1);
  localparam logic [6:0] SEQ_TRL0  = 7'(NDATA);
  localparam logic [6:0] SEQ_TRL1  = 7'(NDATA + 1);

  rcv_state_t    r_state, w_state_nxt;
  logic [6:0]    r_seq, w_seq_nxt;
  logic [6:0]    r_smp;
  logic [3:0]    r_err, w_err_set, w_err_final;
  logic          r_wr_en, r_evt_done, r_evt_err;
  logic [13:0]   r_wr_addr;
  logic [DW-1:0] r_wr_data;

  logic          w_wr, w_crc_en, w_crc_clr, w_done, w_evt_clr, w_smp_inc, w_cnt_bad;
  logic [15:0]   w_crc;
  logic [DW-1:0] w_trl_smp, w_trl_max;

  chnlnk_crc16 #(.INIT(CRC_INIT)) u_crc (
    .CLK (CLK),
    .RST (RST),
    .clr (w_crc_clr),
    .en  (w_crc_en),
    .d   (16'(DIN)),
    .crc (w_crc)
  );

  assign w_trl_smp   = DW'({TRL_SMP_MARK, 5'd0, r_smp});
  assign w_trl_max   = DW'({TRL_MAX_MARK, 5'd0, SAMP_MAX});
  assign w_cnt_bad   = ({1'b0, r_smp} != ({1'b0, SAMP_MAX} + 8'd1));
  assign w_err_final = r_err | w_err_set | {w_cnt_bad, 3'b000};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_seq_nxt   = r_seq;
    w_smp_inc   = 1'b0;
    w_err_set   = '0;
    w_wr        = 1'b0;
    w_crc_en    = 1'b0;
    w_crc_clr   = 1'b0;
    w_done      = 1'b0;
    w_evt_clr   = 1'b0;
    case (r_state)
      ST_IDLE, ST_WAIT: begin
        if (LAST_WRD) begin
          w_done      = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (VALID) begin
          w_wr        = 1'b1;
          w_crc_en    = 1'b1;
          w_seq_nxt   = 7'd1;
          w_state_nxt = ST_DATA;
          if (r_smp > SAMP_MAX) w_err_set[ERR_SMP] = 1'b1;
        end
      end
      ST_DATA: begin
        if (LAST_WRD) begin
          w_err_set[ERR_GAP] = 1'b1;
          w_done             = 1'b1;
          w_state_nxt        = ST_DONE;
        end else if (!VALID) begin
          w_err_set[ERR_GAP] = 1'b1;
          w_state_nxt        = ST_ERRW;
        end else begin
          w_wr      = 1'b1;
          w_crc_en  = 1'b1;
          w_seq_nxt = r_seq + 7'd1;
          if (r_seq == SEQ_DLAST) w_state_nxt = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (LAST_WRD) begin
          w_err_set[ERR_GAP] = 1'b1;
          w_done             = 1'b1;
          w_state_nxt        = ST_DONE;
        end else if (!VALID) begin
          w_err_set[ERR_GAP] = 1'b1;
          w_state_nxt        = ST_ERRW;
        end else if (r_seq == SEQ_TRL0) begin
          w_crc_en  = 1'b1;
          w_seq_nxt = r_seq + 7'd1;
          if (DIN != w_trl_smp) w_err_set[ERR_TRL] = 1'b1;
        end else if (r_seq == SEQ_TRL1) begin
          w_crc_en  = 1'b1;
          w_seq_nxt = r_seq + 7'd1;
          if (DIN != w_trl_max) w_err_set[ERR_TRL] = 1'b1;
        end else begin
          // CRC word: compared against the accumulator, never fed into it.
          if (DIN != DW'(w_crc)) w_err_set[ERR_CRC] = 1'b1;
          w_crc_clr   = 1'b1;
          w_seq_nxt   = '0;
          w_smp_inc   = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_ERRW: begin
        if (LAST_WRD) begin
          w_done      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_evt_clr   = 1'b1;
        w_crc_clr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_seq      <= '0;
      r_smp      <= '0;
      r_err      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_evt_done <= 1'b0;
      r_evt_err  <= 1'b0;
    end else begin
      r_wr_en    <= w_wr;
      r_wr_data  <= DIN;
      r_evt_done <= w_done;
      r_evt_err  <= w_done & (|w_err_final);
      if (w_wr) r_wr_addr <= {r_smp, r_seq};
      if (w_evt_clr) begin
        r_seq <= '0;
        r_smp <= '0;
        r_err <= '0;
      end else begin
        r_seq <= w_seq_nxt;
        if (w_smp_inc && r_smp != 7'h7F) r_smp <= r_smp + 7'd1;
        // The count check is folded in on the closing cycle so ERR_CODE is final during DONE.
        r_err <= w_done ? w_err_final : (r_err | w_err_set);
      end
    end
  end

  assign WR_EN     = r_wr_en;
  assign WR_ADDR   = r_wr_addr;
  assign WR_DATA   = r_wr_data;
  assign EVT_DONE  = r_evt_done;
  assign EVT_ERR   = r_evt_err;
  assign ERR_CODE  = r_err;
  assign RCV_STATE = r_state;

endmodule

// File: tb/tb_chnlnk_frame_rcv_fsm.sv
// Scoreboard bench for the channel-link deframer: expected writes and event
// results are queued as stimulus is driven and checked as the DUT produces them.
module tb_chnlnk_frame_rcv_fsm;

  localparam int MODE_CLEAN   = 0;
  localparam int MODE_CORRUPT = 1;
  localparam int MODE_GAP     = 2;
  localparam int MODE_COLLIDE = 3;
  localparam int MODE_PARTIAL = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [6:0]  SAMP_MAX = '0;
  logic        VALID = 1'b0;
  logic [15:0] DIN = '0;
  logic        LAST_WRD = 1'b0;
  logic        WR_EN, EVT_DONE, EVT_ERR;
  logic [13:0] WR_ADDR;
  logic [15:0] WR_DATA;
  logic [3:0]  ERR_CODE;
  logic [2:0]  RCV_STATE;

  chnlnk_frame_rcv_fsm dut (
    .CLK       (CLK),
    .RST       (RST),
    .SAMP_MAX  (SAMP_MAX),
    .VALID     (VALID),
    .DIN       (DIN),
    .LAST_WRD  (LAST_WRD),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .EVT_DONE  (EVT_DONE),
    .EVT_ERR   (EVT_ERR),
    .ERR_CODE  (ERR_CODE),
    .RCV_STATE (RCV_STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] err;
    int         cyc;
  } evt_t;

  wr_t  exp_wr[$];
  evt_t exp_evt[$];
  wr_t  mon_w;
  evt_t mon_e;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_wr     = 0;
  logic [13:0] last_addr = '0;
  logic [3:0]  last_err  = '0;
  logic [6:0]  m_smp = '0;
  logic [3:0]  m_err = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-at-a-time CRC-16-CCITT reference (XOR word in, then 16 shifts).
  function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 16; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (WR_EN) begin
      if (exp_wr.size() == 0) begin
        check("wr_spurious", 32'(WR_EN), 32'd0);
      end else begin
        mon_w = exp_wr.pop_front();
        check("wr_addr", 32'(WR_ADDR), 32'(mon_w.addr));
        check("wr_data", 32'(WR_DATA), 32'(mon_w.data));
      end
      n_wr++;
      last_addr = WR_ADDR;
    end
    if (EVT_DONE) begin
      if (exp_evt.size() == 0) begin
        check("evt_spurious", 32'(EVT_DONE), 32'd0);
      end else begin
        mon_e = exp_evt.pop_front();
        check("evt_err_code", 32'(ERR_CODE), 32'(mon_e.err));
        check("evt_err", 32'(EVT_ERR), 32'(|mon_e.err));
        check("evt_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
      last_err = ERR_CODE;
    end
  end

  task automatic drive(input logic v, input logic l, input logic [15:0] d);
    VALID    = v;
    LAST_WRD = l;
    DIN      = d;
    @(posedge CLK);
    #1;
    VALID    = 1'b0;
    LAST_WRD = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic push_evt();
    logic [3:0] e;
    e = m_err | ((({1'b0, m_smp}) != ({1'b0, SAMP_MAX} + 8'd1)) ? 4'h8 : 4'h0);
    exp_evt.push_back('{e, cyc + 1});
  endtask

  task automatic wait_evt();
    for (int i = 0; i < 8; i++) begin
      if (exp_evt.size() == 0) break;
      @(negedge CLK);
    end
    #1;
    check("evt_pending", 32'(exp_evt.size()), 32'd0);
    check("wr_pending", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic send_last();
    push_evt();
    drive(1'b0, 1'b1, 16'h0000);
    m_smp = '0;
    m_err = '0;
    wait_evt();
  endtask

  task automatic send_frame(input int mode, input int pos, input int idle_after);
    logic [15:0] crc, w, sw;
    bit          dead;
    crc  = 16'hFFFF;
    dead = 1'b0;
    if (m_smp > SAMP_MAX) m_err[3] = 1'b1;
    for (int s = 0; s < 99; s++) begin
      if (s < 96)       w = 16'($urandom);
      else if (s == 96) w = {4'hD, 5'd0, m_smp};
      else if (s == 97) w = {4'hE, 5'd0, SAMP_MAX};
      else              w = crc;
      if (s < 98) crc = crc_ref(crc, w);
      sw = (mode == MODE_CORRUPT && s == pos) ? (w ^ 16'h0100) : w;
      if (s == pos) begin
        if (mode == MODE_GAP) begin
          drive(1'b0, 1'b0, 16'h0000);
          m_err[0] = 1'b1;
          dead     = 1'b1;
        end else if (mode == MODE_COLLIDE) begin
          m_err[0] = 1'b1;
          push_evt();
          drive(1'b1, 1'b1, sw);
          m_smp = '0;
          m_err = '0;
          return;
        end else if (mode == MODE_PARTIAL) begin
          return;
        end
      end
      if (!dead && s < 96) exp_wr.push_back('{{m_smp, 7'(s)}, sw});
      drive(1'b1, 1'b0, sw);
    end
    if (!dead) begin
      if (m_smp != 7'h7F) m_smp++;
      if (mode == MODE_CORRUPT) m_err[2] = 1'b1;
    end
    idle(idle_after);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, 32'(WR_EN), 32'd0);
    check({tag, "_wr_addr"}, 32'(WR_ADDR), 32'd0);
    check({tag, "_wr_data"}, 32'(WR_DATA), 32'd0);
    check({tag, "_evt_done"}, 32'(EVT_DONE), 32'd0);
    check({tag, "_evt_err"}, 32'(EVT_ERR), 32'd0);
    check({tag, "_err_code"}, 32'(ERR_CODE), 32'd0);
    check({tag, "_state"}, 32'(RCV_STATE), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    RST = 1'b0;
    idle(2);

    // Single clean sample
    SAMP_MAX = 7'd0;
    n_wr = 0;
    send_frame(MODE_CLEAN, -1, 2);
    send_last();
    check("t1_nwr", 32'(n_wr), 32'd96);
    check("t1_last_addr", 32'(last_addr), 32'h005F);
    check("t1_err", 32'(last_err), 32'd0);

    // Eight samples with random inter-frame idle
    SAMP_MAX = 7'd7;
    n_wr = 0;
    for (int f = 0; f < 8; f++) send_frame(MODE_CLEAN, -1, $urandom_range(0, 5));
    send_last();
    check("t2_nwr", 32'(n_wr), 32'd768);
    check("t2_last_addr", 32'(last_addr), 32'h03DF);
    check("t2_err", 32'(last_err), 32'd0);

    // Data corruption in sample 2 -> CRC error only
    SAMP_MAX = 7'd3;
    for (int f = 0; f < 4; f++) send_frame((f == 2) ? MODE_CORRUPT : MODE_CLEAN, 40, 1);
    send_last();
    check("t3_err", 32'(last_err), 32'h4);

    // VALID gap at seq 50 -> gap error, remaining words ignored
    SAMP_MAX = 7'd0;
    n_wr = 0;
    send_frame(MODE_GAP, 50, 2);
    send_last();
    check("t4_nwr", 32'(n_wr), 32'd50);
    check("t4_err", 32'(last_err), 32'h9);
    send_frame(MODE_CLEAN, -1, 1);
    send_last();
    check("t4_next_err", 32'(last_err), 32'd0);

    // Sample count short and long
    SAMP_MAX = 7'd3;
    for (int f = 0; f < 3; f++) send_frame(MODE_CLEAN, -1, 1);
    send_last();
    check("t5_short_err", 32'(last_err), 32'h8);
    for (int f = 0; f < 5; f++) send_frame(MODE_CLEAN, -1, 1);
    send_last();
    check("t5_long_err", 32'(last_err), 32'h8);
    check("t5_long_last_addr", 32'(last_addr), 32'h025F);

    // LAST_WRD together with VALID mid-frame
    SAMP_MAX = 7'd0;
    n_wr = 0;
    send_frame(MODE_COLLIDE, 10, 0);
    wait_evt();
    check("t7_nwr", 32'(n_wr), 32'd10);
    check("t7_err", 32'(last_err), 32'h9);

    // Reset in the middle of sample 1
    SAMP_MAX = 7'd1;
    send_frame(MODE_CLEAN, -1, 1);
    send_frame(MODE_PARTIAL, 30, 0);
    @(negedge CLK);
    #1;
    check("t6_wr_drained", 32'(exp_wr.size()), 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_outputs_zero("t6_rst");
    repeat (2) @(posedge CLK);
    #1;
    RST   = 1'b0;
    m_smp = '0;
    m_err = '0;
    idle(2);
    SAMP_MAX = 7'd0;
    n_wr = 0;
    send_frame(MODE_CLEAN, -1, 0);
    send_last();
    check("t6_nwr", 32'(n_wr), 32'd96);
    check("t6_last_addr", 32'(last_addr), 32'h005F);
    check("t6_err", 32'(last_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
